// File: rtl/pu_window_feeder.sv
// Operand sequencer / result collector for a 4-input PU: streams sliding
// 4-element windows with fixed weights and gathers the delayed PU results.
module pu_window_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int LAT   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_addr,
  input  logic [4:0]    buf_wdata,
  input  logic          w_we,
  input  logic [1:0]    w_sel,
  input  logic [4:0]    w_wdata,
  input  logic          start,
  input  logic [AW-1:0] num_win,
  output logic [4:0]    pu_in1,
  output logic [4:0]    pu_in2,
  output logic [4:0]    pu_in3,
  output logic [4:0]    pu_in4,
  output logic [4:0]    pu_w1,
  output logic [4:0]    pu_w2,
  output logic [4:0]    pu_w3,
  output logic [4:0]    pu_w4,
  input  logic [11:0]   pu_out,
  output logic          res_valid,
  output logic [11:0]   res_data,
  output logic [AW-1:0] res_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  localparam logic [AW-1:0] NMAX = AW'(DEPTH - 3);

  state_t        state_q, state_d;
  logic [4:0]    buf_q [DEPTH];
  logic [4:0]    buf_d [DEPTH];
  logic [4:0]    wgt_q [4];
  logic [4:0]    wgt_d [4];
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] n_q, n_d;
  logic [4:0]    op_in_q [4];
  logic [4:0]    op_in_d [4];
  logic [4:0]    op_w_q [4];
  logic [4:0]    op_w_d [4];
  logic [LAT-1:0] vld_q, vld_d;
  logic [AW-1:0] idx_q [LAT];
  logic [AW-1:0] idx_d [LAT];
  logic          res_valid_q, res_valid_d;
  logic [11:0]   res_data_q, res_data_d;
  logic [AW-1:0] res_idx_q, res_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pending;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    wgt_d   = wgt_q;
    k_d     = k_q;
    n_d     = n_q;
    for (int unsigned j = 0; j < 4; j++) begin
      op_in_d[j] = '0;
      op_w_d[j]  = '0;
    end
    vld_d    = vld_q << 1;
    idx_d[0] = '0;
    for (int unsigned i = 1; i < LAT; i++) idx_d[i] = idx_q[i-1];

    res_valid_d = vld_q[LAT-1];
    res_idx_d   = vld_q[LAT-1] ? idx_q[LAT-1] : res_idx_q;
    res_data_d  = res_valid_q ? pu_out : res_data_q;

    // The window in the last pipe stage strobes next cycle, so FIN can
    // follow directly and land done one cycle after the final strobe.
    pending = 1'b0;
    for (int unsigned i = 0; i + 1 < LAT; i++) pending = pending | vld_q[i];

    busy_d = (state_q != IDLE);
    done_d = (state_q == FIN);

    case (state_q)
      IDLE: begin
        if (buf_we) buf_d[buf_addr] = buf_wdata;
        if (w_we)   wgt_d[w_sel]    = w_wdata;
        if (start) begin
          n_d     = (num_win > NMAX) ? NMAX : num_win;
          k_d     = '0;
          state_d = (n_d == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        for (int unsigned j = 0; j < 4; j++) begin
          op_in_d[j] = buf_q[k_q + AW'(j)];
          op_w_d[j]  = wgt_q[j];
        end
        vld_d[0] = 1'b1;
        idx_d[0] = k_q;
        k_d      = k_q + AW'(1);
        if (k_q == n_q - AW'(1)) state_d = DRAIN;
      end
      DRAIN: if (!pending) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      n_q         <= '0;
      for (int unsigned j = 0; j < 4; j++) begin
        wgt_q[j]   <= '0;
        op_in_q[j] <= '0;
        op_w_q[j]  <= '0;
      end
      vld_q       <= '0;
      for (int unsigned i = 0; i < LAT; i++) idx_q[i] <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      wgt_q       <= wgt_d;
      op_in_q     <= op_in_d;
      op_w_q      <= op_w_d;
      vld_q       <= vld_d;
      idx_q       <= idx_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign pu_in1 = op_in_q[0];
  assign pu_in2 = op_in_q[1];
  assign pu_in3 = op_in_q[2];
  assign pu_in4 = op_in_q[3];
  assign pu_w1  = op_w_q[0];
  assign pu_w2  = op_w_q[1];
  assign pu_w3  = op_w_q[2];
  assign pu_w4  = op_w_q[3];

  // pu_out is only valid in the strobe cycle itself, so it is forwarded
  // then and the captured copy is held afterwards.
  assign res_valid = res_valid_q;
  assign res_data  = res_valid_q ? pu_out : res_data_q;
  assign res_idx   = res_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pu_window_feeder.sv
// Bench for pu_window_feeder: a 2-register PU model is attached and each
// job's observed stream is compared against sliding-window dot products.
module tb_pu_window_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LAT   = 2;
  localparam int CAP   = 48;

  logic          clk = 1'b0;
  logic          rst, buf_we, w_we, start;
  logic [AW-1:0] buf_addr, num_win;
  logic [4:0]    buf_wdata, w_wdata;
  logic [1:0]    w_sel;
  logic [4:0]    pu_in1, pu_in2, pu_in3, pu_in4;
  logic [4:0]    pu_w1, pu_w2, pu_w3, pu_w4;
  logic [11:0]   pu_out = '0;
  logic [11:0]   p1 = '0;
  logic          res_valid, busy, done;
  logic [11:0]   res_data;
  logic [AW-1:0] res_idx;

  pu_window_feeder #(.DEPTH(DEPTH), .AW(AW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .w_we(w_we), .w_sel(w_sel), .w_wdata(w_wdata),
    .start(start), .num_win(num_win),
    .pu_in1(pu_in1), .pu_in2(pu_in2), .pu_in3(pu_in3), .pu_in4(pu_in4),
    .pu_w1(pu_w1), .pu_w2(pu_w2), .pu_w3(pu_w3), .pu_w4(pu_w4),
    .pu_out(pu_out),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Processing unit: dot product through two pipeline registers.
  always @(posedge clk) begin
    p1     <= 12'(pu_in1) * 12'(pu_w1) + 12'(pu_in2) * 12'(pu_w2)
            + 12'(pu_in3) * 12'(pu_w3) + 12'(pu_in4) * 12'(pu_w4);
    pu_out <= p1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int bufm [DEPTH];
  int wm   [4];

  logic          rv_a [CAP];
  logic [11:0]   rd_a [CAP];
  logic [AW-1:0] ri_a [CAP];
  logic          bz_a [CAP];
  logic          dn_a [CAP];
  logic [19:0]   op_a [CAP];
  logic [19:0]   wt_a [CAP];
  int            rst_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_buf(input int a, input int d);
    buf_we = 1'b1; buf_addr = AW'(a); buf_wdata = 5'(d);
    tick();
    buf_we = 1'b0;
    bufm[a] = d;
  endtask

  task automatic write_w(input int s, input int d);
    w_we = 1'b1; w_sel = 2'(s); w_wdata = 5'(d);
    tick();
    w_we = 1'b0;
    wm[s] = d;
  endtask

  function automatic int exp_res(int k);
    int s = 0;
    for (int j = 0; j < 4; j++) s += bufm[k+j] * wm[j];
    return s;
  endfunction

  function automatic logic [19:0] exp_ops(int k);
    return {5'(bufm[k]), 5'(bufm[k+1]), 5'(bufm[k+2]), 5'(bufm[k+3])};
  endfunction

  function automatic logic [19:0] exp_wts();
    return {5'(wm[0]), 5'(wm[1]), 5'(wm[2]), 5'(wm[3])};
  endfunction

  function automatic int first_op();
    for (int t = 1; t < CAP; t++) if (op_a[t] != '0) return t;
    return -1;
  endfunction

  // mode 0: plain job; 1: start + buf[2] write mid-issue; 2: reset on idx 1 strobe.
  task automatic capture(input int nw, input int mode);
    rst_t   = -1;
    num_win = AW'(nw);
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < CAP; t++) begin
      rv_a[t] = res_valid; rd_a[t] = res_data; ri_a[t] = res_idx;
      bz_a[t] = busy;      dn_a[t] = done;
      op_a[t] = {pu_in1, pu_in2, pu_in3, pu_in4};
      wt_a[t] = {pu_w1, pu_w2, pu_w3, pu_w4};
      if (mode == 1) begin
        start = (t == 3); buf_we = (t == 3); buf_addr = AW'(2); buf_wdata = 5'd31;
      end else if (mode == 2) begin
        if (rst) rst = 1'b0;
        else if (rst_t < 0 && res_valid && res_idx == AW'(1)) begin
          rst = 1'b1; rst_t = t;
        end
      end
      tick();
    end
    start = 1'b0; buf_we = 1'b0; rst = 1'b0;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 8; i++) write_buf(i, i + 1);
    for (int j = 0; j < 4; j++) write_w(j, 1);
  endtask

  task automatic load_random();
    for (int i = 0; i < DEPTH; i++) write_buf(i, int'($urandom_range(0, 31)));
    for (int j = 0; j < 4; j++) write_w(j, int'($urandom_range(0, 31)));
  endtask

  task automatic test_reset();
    rst = 1'b1; buf_we = 0; w_we = 0; start = 0;
    buf_addr = '0; buf_wdata = '0; w_sel = '0; w_wdata = '0; num_win = '0;
    repeat (3) tick();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %0d, expected 0", res_valid); end
    n_checks++; if (res_data !== 12'd0) begin n_fail++; $display("FAIL reset_res_data: got %0d, expected 0", res_data); end
    n_checks++; if (res_idx !== '0) begin n_fail++; $display("FAIL reset_res_idx: got %0d, expected 0", res_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d, expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0d, expected 0", done); end
    n_checks++;
    if ({pu_in1, pu_in2, pu_in3, pu_in4, pu_w1, pu_w2, pu_w3, pu_w4} !== 40'd0) begin
      n_fail++; $display("FAIL reset_operands: got %h, expected 0",
                         {pu_in1, pu_in2, pu_in3, pu_in4, pu_w1, pu_w2, pu_w3, pu_w4});
    end
    for (int j = 0; j < 4; j++) wm[j] = 0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int w0, k, kw, dt;
    logic e_rv;
    logic [19:0] e_op, e_wt;
    load_basic();
    capture(5, 0);
    w0 = first_op();
    n_checks++; if (w0 < 0) begin n_fail++; $display("FAIL basic_window0: got none, expected a window"); w0 = 1000; end
    dt = w0 + LAT + 5;
    for (int t = 1; t < CAP; t++) begin
      k  = t - w0 - LAT;
      kw = t - w0;
      e_rv = (k >= 0 && k < 5);
      n_checks++; if (rv_a[t] !== e_rv) begin n_fail++; $display("FAIL basic_valid@%0d: got %0d, expected %0d", t, rv_a[t], e_rv); end
      if (e_rv) begin
        n_checks++; if (rd_a[t] !== 12'(exp_res(k))) begin n_fail++; $display("FAIL basic_data@%0d: got %0d, expected %0d", t, rd_a[t], exp_res(k)); end
        n_checks++; if (ri_a[t] !== AW'(k)) begin n_fail++; $display("FAIL basic_idx@%0d: got %0d, expected %0d", t, ri_a[t], k); end
      end
      n_checks++; if (dn_a[t] !== (t == dt)) begin n_fail++; $display("FAIL basic_done@%0d: got %0d, expected %0d", t, dn_a[t], t == dt); end
      n_checks++; if (bz_a[t] !== (t >= w0 && t <= dt)) begin n_fail++; $display("FAIL basic_busy@%0d: got %0d, expected %0d", t, bz_a[t], t >= w0 && t <= dt); end
      e_op = (kw >= 0 && kw < 5) ? exp_ops(kw) : '0;
      e_wt = (kw >= 0 && kw < 5) ? exp_wts() : '0;
      n_checks++; if (op_a[t] !== e_op) begin n_fail++; $display("FAIL basic_pu_in@%0d: got %h, expected %h", t, op_a[t], e_op); end
      n_checks++; if (wt_a[t] !== e_wt) begin n_fail++; $display("FAIL basic_pu_w@%0d: got %h, expected %h", t, wt_a[t], e_wt); end
    end
  endtask

  task automatic test_latency();
    int t5, cnt, st;
    write_buf(0, 5); write_buf(1, 7); write_buf(2, 9); write_buf(3, 11);
    write_w(0, 2); write_w(1, 0); write_w(2, 0); write_w(3, 3);
    capture(1, 0);
    t5 = -100; cnt = 0; st = -100;
    for (int t = CAP - 1; t >= 1; t--) if (op_a[t][19:15] == 5'd5) t5 = t;
    for (int t = 1; t < CAP; t++) if (rv_a[t]) begin cnt++; st = t; end
    n_checks++; if (cnt != 1) begin n_fail++; $display("FAIL lat_count: got %0d, expected 1", cnt); end
    n_checks++; if (st != t5 + LAT) begin n_fail++; $display("FAIL lat_cycle: got %0d, expected %0d", st, t5 + LAT); end
    if (st > 0) begin
      n_checks++; if (rd_a[st] !== 12'd43) begin n_fail++; $display("FAIL lat_data: got %0d, expected 43", rd_a[st]); end
      n_checks++; if (ri_a[st] !== '0) begin n_fail++; $display("FAIL lat_idx: got %0d, expected 0", ri_a[st]); end
      n_checks++; if (dn_a[st+1] !== 1'b1) begin n_fail++; $display("FAIL lat_done: got %0d, expected 1", dn_a[st+1]); end
    end
  endtask

  task automatic test_clamp();
    int cnt, last, w0;
    load_random();
    capture(15, 0);
    cnt = 0; last = -1;
    for (int t = 1; t < CAP; t++) if (rv_a[t]) begin
      n_checks++; if (ri_a[t] !== AW'(cnt)) begin n_fail++; $display("FAIL clamp_idx@%0d: got %0d, expected %0d", t, ri_a[t], cnt); end
      if (cnt < DEPTH - 3) begin
        n_checks++; if (rd_a[t] !== 12'(exp_res(cnt))) begin n_fail++; $display("FAIL clamp_data@%0d: got %0d, expected %0d", t, rd_a[t], exp_res(cnt)); end
      end
      if (last >= 0) begin
        n_checks++; if (t != last + 1) begin n_fail++; $display("FAIL clamp_gap: got %0d, expected %0d", t, last + 1); end
      end
      last = t; cnt++;
    end
    n_checks++; if (cnt != DEPTH - 3) begin n_fail++; $display("FAIL clamp_count: got %0d, expected %0d", cnt, DEPTH - 3); end
    if (last > 0) begin
      n_checks++; if (ri_a[last] !== AW'(12)) begin n_fail++; $display("FAIL clamp_last_idx: got %0d, expected 12", ri_a[last]); end
      n_checks++; if (dn_a[last+1] !== 1'b1) begin n_fail++; $display("FAIL clamp_done: got %0d, expected 1", dn_a[last+1]); end
    end
    w0 = first_op();
    if (w0 > 0) begin
      n_checks++; if (op_a[w0+12] !== exp_ops(12)) begin n_fail++; $display("FAIL clamp_last_window: got %h, expected %h", op_a[w0+12], exp_ops(12)); end
    end
  endtask

  task automatic test_zero();
    capture(0, 0);
    for (int t = 1; t < CAP; t++) begin
      n_checks++; if (rv_a[t] !== 1'b0) begin n_fail++; $display("FAIL zero_valid@%0d: got %0d, expected 0", t, rv_a[t]); end
      n_checks++; if (dn_a[t] !== (t == 2)) begin n_fail++; $display("FAIL zero_done@%0d: got %0d, expected %0d", t, dn_a[t], t == 2); end
      n_checks++; if (bz_a[t] !== (t == 2)) begin n_fail++; $display("FAIL zero_busy@%0d: got %0d, expected %0d", t, bz_a[t], t == 2); end
    end
  endtask

  task automatic test_busy_ignore();
    int cnt, last, dcnt, dt;
    load_basic();
    capture(5, 1);
    cnt = 0; last = -1; dcnt = 0; dt = -1;
    for (int t = 1; t < CAP; t++) begin
      if (rv_a[t]) begin
        n_checks++; if (ri_a[t] !== AW'(cnt)) begin n_fail++; $display("FAIL ignore_idx@%0d: got %0d, expected %0d", t, ri_a[t], cnt); end
        n_checks++; if (rd_a[t] !== 12'(exp_res(cnt))) begin n_fail++; $display("FAIL ignore_data@%0d: got %0d, expected %0d", t, rd_a[t], exp_res(cnt)); end
        last = t; cnt++;
      end
      if (dn_a[t]) begin dcnt++; dt = t; end
    end
    n_checks++; if (cnt != 5) begin n_fail++; $display("FAIL ignore_count: got %0d, expected 5", cnt); end
    n_checks++; if (dcnt != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d, expected 1", dcnt); end
    n_checks++; if (dt != last + 1) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d, expected %0d", dt, last + 1); end
  endtask

  task automatic test_reset_midjob();
    int cnt, dcnt, last;
    load_basic();
    capture(5, 2);
    n_checks++; if (rst_t < 0) begin n_fail++; $display("FAIL midrst_trigger: got none, expected idx 1 strobe"); rst_t = CAP - 2; end
    n_checks++; if ({rv_a[rst_t+1], bz_a[rst_t+1], dn_a[rst_t+1]} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_flags: got %b, expected 000", {rv_a[rst_t+1], bz_a[rst_t+1], dn_a[rst_t+1]}); end
    n_checks++; if ({rd_a[rst_t+1], ri_a[rst_t+1]} !== '0) begin
      n_fail++; $display("FAIL midrst_result: got %0d/%0d, expected 0/0", rd_a[rst_t+1], ri_a[rst_t+1]); end
    n_checks++; if ({op_a[rst_t+1], wt_a[rst_t+1]} !== 40'd0) begin
      n_fail++; $display("FAIL midrst_operands: got %h, expected 0", {op_a[rst_t+1], wt_a[rst_t+1]}); end
    cnt = 0; dcnt = 0;
    for (int t = 1; t < CAP; t++) begin
      if (rv_a[t]) cnt++;
      if (t > rst_t && dn_a[t]) dcnt++;
    end
    n_checks++; if (cnt != 2) begin n_fail++; $display("FAIL midrst_strobes: got %0d, expected 2", cnt); end
    n_checks++; if (dcnt != 0) begin n_fail++; $display("FAIL midrst_done: got %0d, expected 0", dcnt); end
    for (int j = 0; j < 4; j++) write_w(j, 1);
    capture(5, 0);
    cnt = 0; last = -1;
    for (int t = 1; t < CAP; t++) if (rv_a[t]) begin
      n_checks++; if (ri_a[t] !== AW'(cnt)) begin n_fail++; $display("FAIL rerun_idx@%0d: got %0d, expected %0d", t, ri_a[t], cnt); end
      n_checks++; if (rd_a[t] !== 12'(exp_res(cnt))) begin n_fail++; $display("FAIL rerun_data@%0d: got %0d, expected %0d", t, rd_a[t], exp_res(cnt)); end
      last = t; cnt++;
    end
    n_checks++; if (cnt != 5) begin n_fail++; $display("FAIL rerun_count: got %0d, expected 5", cnt); end
    if (last > 0) begin
      n_checks++; if (dn_a[last+1] !== 1'b1) begin n_fail++; $display("FAIL rerun_done: got %0d, expected 1", dn_a[last+1]); end
    end
  endtask

  task automatic test_random();
    int nw, n_exp, cnt, last, dcnt, dt;
    for (int it = 0; it < 4; it++) begin
      load_random();
      nw    = int'($urandom_range(0, 15));
      n_exp = (nw > DEPTH - 3) ? DEPTH - 3 : nw;
      capture(nw, 0);
      cnt = 0; last = -1; dcnt = 0; dt = -1;
      for (int t = 1; t < CAP; t++) begin
        if (rv_a[t]) begin
          n_checks++; if (ri_a[t] !== AW'(cnt)) begin n_fail++; $display("FAIL rand_idx@%0d: got %0d, expected %0d", t, ri_a[t], cnt); end
          if (cnt < DEPTH - 3) begin
            n_checks++; if (rd_a[t] !== 12'(exp_res(cnt))) begin n_fail++; $display("FAIL rand_data@%0d: got %0d, expected %0d", t, rd_a[t], exp_res(cnt)); end
          end
          if (last >= 0) begin
            n_checks++; if (t != last + 1) begin n_fail++; $display("FAIL rand_gap: got %0d, expected %0d", t, last + 1); end
          end
          last = t; cnt++;
        end
        if (dn_a[t]) begin dcnt++; dt = t; end
      end
      n_checks++; if (cnt != n_exp) begin n_fail++; $display("FAIL rand_count(nw=%0d): got %0d, expected %0d", nw, cnt, n_exp); end
      n_checks++; if (dcnt != 1) begin n_fail++; $display("FAIL rand_done_count: got %0d, expected 1", dcnt); end
      n_checks++; if (dt != ((n_exp == 0) ? 2 : last + 1)) begin
        n_fail++; $display("FAIL rand_done_cycle: got %0d, expected %0d", dt, (n_exp == 0) ? 2 : last + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_clamp();
    test_zero();
    test_busy_ignore();
    test_reset_midjob();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pu_window_feeder.md
Name: pu_window_feeder

Overview:
- Operand sequencer and result collector sitting on the far side of a 4-input processing unit (PU).
- Holds an input line buffer and four weight registers, and streams sliding 4-element windows (buf[k..k+3]) with the fixed weights onto the PU operand ports, one window per cycle.
- Accounts for the PU's fixed 2-register pipeline latency and captures each 12-bit PU result into an ordered, indexed result stream.
- Frames each job with start/busy/done.

Parameters:
- DEPTH, 16, input buffer entries; must be >= 4.
- AW, 4, buffer address width, clog2(DEPTH).
- LAT, 2, PU latency in cycles from operands presented to result on pu_out.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- buf_we  in  1  input buffer write enable.
- buf_addr  in  AW  input buffer write address.
- buf_wdata  in  5  input buffer write data.
- w_we  in  1  weight register write enable.
- w_sel  in  2  weight index 0..3.
- w_wdata  in  5  weight write data.
- start  in  1  job start pulse.
- num_win  in  AW  number of windows to issue.
- pu_in1..pu_in4  out  5 each  PU input operands (window elements k..k+3).
- pu_w1..pu_w4  out  5 each  PU weight operands.
- pu_out  in  12  PU result.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  12  captured PU result.
- res_idx  out  AW  window index of res_data.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.

Behaviour:
- Reset: all listed outputs 0, FSM to IDLE, issue counter 0, latency valid pipe cleared, weight registers 0.
  - Buffer contents are not reset.
  - Reset mid-job aborts immediately; no res_valid or done is produced for the aborted job.
- Writes:
  - buf_we and w_we are honoured only in IDLE; they are ignored in any other state.
  - A write and start in the same IDLE cycle: the write lands first, so the job sees the new value.
- FSM states:
  - IDLE: busy=0. On start: latch N = min(num_win, DEPTH-3), k=0.
    - If N=0: go to FIN.
    - Otherwise: go to ISSUE.
  - ISSUE: busy=1.
    - Registered pu_inj = buf[k+j-1] and pu_wj = weight[j-1] are visible for exactly one cycle per k.
    - k increments each cycle; after k=N-1 is issued, go to DRAIN.
  - DRAIN: busy=1. Wait until the valid pipe is empty, then go to FIN.
  - FIN: busy=1, done=1 for one cycle, then IDLE.
  - start is ignored in every state except IDLE.
- Operand outputs:
  - pu_in*/pu_w* are registered.
  - They are driven to 0 in every cycle in which no window is being issued, so the PU sees zero operands outside jobs.
- Latency tracking:
  - A LAT-deep shift register carries {valid, k} alongside the PU pipeline.
  - If window k is visible on the operand ports in cycle t, then in cycle t+LAT: res_valid=1, res_data=pu_out sampled that cycle, res_idx=k.
  - res_data and res_idx are registered outputs updated on that strobe. They hold their value otherwise; res_valid is 0 otherwise.
- Result order: results are strictly in index order, one per cycle, back-to-back, N strobes per job.
- done: asserts the cycle after the last res_valid. With N=0, done asserts 2 cycles after start.
- Width rules:
  - Window addresses k+j never exceed DEPTH-1 because of the clamp; there is no wrap.
  - res_data is passed through unmodified at 12 bits.

Test Plan:
- Basic job: buf[i]=i+1 for i=0..7, weights 1,1,1,1, start with num_win=5, real PU attached.
  - Required: res_idx 0..4 with res_data 10,14,18,22,26 on consecutive cycles.
  - First strobe exactly LAT cycles after window 0 appears on pu_in; done the cycle after idx 4.
- Latency alignment: weights 2,0,0,3, buf[0..3]=5,7,9,11, num_win=1.
  - Required: single strobe res_data=43, idx 0, two cycles after pu_in1=5.
- Clamp: DEPTH=16, num_win=15.
  - Required: exactly 13 strobes, last idx 12 using buf[12..15]; no out-of-range read.
- Zero job: num_win=0.
  - Required: no res_valid; done one-cycle pulse 2 cycles after start; busy high only in the FIN cycle.
- Illegal activity while busy:
  - start pulse during ISSUE: ignored, the job is not restarted.
  - buf_we to buf[2] during ISSUE: ignored, results unchanged vs basic job.
- Reset mid-job: assert rst on the cycle res_idx=1 is strobed.
  - Required: next cycle all outputs 0, state IDLE, no further strobes or done.
  - A fresh start then runs the basic job correctly.
